// File: rtl/scan_chain_ctrl.sv
// Tester-side scan chain driver: shifts a pattern in on si with se=1, runs the
// functional capture clocks with se=0, then unloads so and compares it against a masked expected response.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN      = 16,
  parameter int CAPTURE_CYCLES = 1,
  parameter int CNT_W          = 5
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pat_in,
  input  logic [CHAIN_LEN-1:0] exp_in,
  input  logic [CHAIN_LEN-1:0] mask_in,
  input  logic                 so,
  output logic                 se,
  output logic                 si,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CHAIN_LEN-1:0] resp,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CAPT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAPT_LAST  = CNT_W'(CAPTURE_CYCLES - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_sr;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  logic [CHAIN_LEN-1:0] resp_next;

  assign state_dbg = state;

  // RESP with the current unload bit merged in, so the final compare sees the last SO.
  always_comb begin
    resp_next = resp;
    for (int k = 0; k < CHAIN_LEN; k++) begin
      if (state == UNLOAD && cnt == CNT_W'(k)) resp_next[k] = so;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      pat_sr <= '0;
      exp_q  <= '0;
      mask_q <= '0;
      se     <= 1'b0;
      si     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      fail   <= 1'b0;
      resp   <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        cnt   <= '0;
        se    <= 1'b0;
        si    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state  <= SHIFT;
              cnt    <= '0;
              pat_sr <= pat_in >> 1;
              exp_q  <= exp_in;
              mask_q <= mask_in;
              se     <= 1'b1;
              si     <= pat_in[0];
              busy   <= 1'b1;
            end
          end
          SHIFT: begin
            if (cnt == SHIFT_LAST) begin
              state <= CAPT;
              cnt   <= '0;
              se    <= 1'b0;
              si    <= 1'b0;
            end else begin
              cnt    <= cnt + 1'b1;
              si     <= pat_sr[0];
              pat_sr <= pat_sr >> 1;
            end
          end
          CAPT: begin
            if (cnt == CAPT_LAST) begin
              state <= UNLOAD;
              cnt   <= '0;
              se    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          UNLOAD: begin
            resp <= resp_next;
            if (cnt == SHIFT_LAST) begin
              state <= IDLE;
              cnt   <= '0;
              se    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              fail  <= |((resp_next ^ exp_q) & mask_q);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: a 16-cell SDFF chain model on se/si/so, with
// expected per-cycle pin values derived from the pattern timeline.
module tb_scan_chain_ctrl;

  localparam int N      = 16;
  localparam int C      = 1;
  localparam int IW     = $clog2(N);
  localparam int DONE_K = 2 * N + C + 1;

  logic         ck = 1'b0;
  logic         rst, start, abort, so;
  logic         se, si, busy, done, fail;
  logic [N-1:0] pat_in, exp_in, mask_in, resp;
  logic [1:0]   state_dbg;

  logic [N-1:0] chain = '0;
  logic         inv_mode = 1'b0;
  logic         model_fail;
  int           checks = 0;
  int           errors = 0;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(C), .CNT_W(5)) dut (
    .ck(ck), .rst(rst), .start(start), .abort(abort),
    .pat_in(pat_in), .exp_in(exp_in), .mask_in(mask_in), .so(so),
    .se(se), .si(si), .busy(busy), .done(done), .fail(fail),
    .resp(resp), .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 ck = ~ck;

  // Chain of SDFF cells: se selects si, otherwise capture holds or inverts Q.
  always @(posedge ck) begin
    if (se) chain <= {chain[N-2:0], si};
    else if (inv_mode) chain <= ~chain;
  end
  assign so = chain[N-1];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Runs one pattern from the cycle before its accepting edge. abort_k/rst_k
  // (0 = none) inject ABORT at the end of cycle k, or RST during cycle k.
  task automatic run_pattern(input logic [N-1:0] pat, input logic [N-1:0] ex,
                             input logic [N-1:0] mask, input logic inv, input logic hold,
                             input int abort_k, input int rst_k);
    logic [N-1:0] want_resp;
    logic         want_fail, want_se, want_si, want_busy, want_done;
    want_resp = (inv && (C % 2 == 1)) ? ~pat : pat;
    want_fail = |((want_resp ^ ex) & mask);
    pat_in   = pat;
    exp_in   = ex;
    mask_in  = mask;
    inv_mode = inv;
    start    = 1'b1;
    abort    = 1'b0;
    @(posedge ck);
    for (int k = 1; k <= DONE_K; k++) begin
      @(negedge ck);
      want_se   = (k <= N) || (k > N + C && k <= 2 * N + C);
      want_si   = (k <= N) ? pat[IW'(k - 1)] : 1'b0;
      want_busy = (k <= 2 * N + C);
      want_done = (k == DONE_K);
      check($sformatf("se@%0d", k), N'(se), N'(want_se));
      check($sformatf("si@%0d", k), N'(si), N'(want_si));
      check($sformatf("busy@%0d", k), N'(busy), N'(want_busy));
      check($sformatf("done@%0d", k), N'(done), N'(want_done));
      if (k == DONE_K) begin
        check("resp", resp, want_resp);
        check("fail", N'(fail), N'(want_fail));
        model_fail = want_fail;
      end
      if (k == rst_k) begin
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("rst_se", N'(se), '0);
        check("rst_si", N'(si), '0);
        check("rst_busy", N'(busy), '0);
        check("rst_done", N'(done), '0);
        check("rst_fail", N'(fail), '0);
        check("rst_resp", resp, '0);
        model_fail = 1'b0;
        @(negedge ck);
        rst = 1'b0;
        return;
      end
      if (k == abort_k) begin
        start = 1'b0;
        abort = 1'b1;
        @(negedge ck);
        abort = 1'b0;
        check("abort_se", N'(se), '0);
        check("abort_si", N'(si), '0);
        check("abort_busy", N'(busy), '0);
        check("abort_done", N'(done), '0);
        check("abort_fail", N'(fail), N'(model_fail));
        check("abort_resp_low", N'(resp[4:0]), N'(want_resp[4:0]));
        for (int j = 0; j < N; j++) begin
          @(negedge ck);
          check($sformatf("post_abort_done@%0d", j), N'(done), '0);
          check($sformatf("post_abort_busy@%0d", j), N'(busy), '0);
        end
        return;
      end
      if (k < DONE_K) begin
        start   = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
        pat_in  = N'($urandom);
        exp_in  = N'($urandom);
        mask_in = N'($urandom);
      end else if (!hold) begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] p, m, e;
    logic         iv;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pat_in = '0; exp_in = '0; mask_in = '0;
    model_fail = 1'b0;
    repeat (2) @(negedge ck);
    check("reset_se", N'(se), '0);
    check("reset_si", N'(si), '0);
    check("reset_busy", N'(busy), '0);
    check("reset_done", N'(done), '0);
    check("reset_fail", N'(fail), '0);
    check("reset_resp", resp, '0);
    rst = 1'b0;
    @(negedge ck);

    run_pattern(16'hA5C3, 16'hA5C3, 16'hFFFF, 1'b0, 1'b0, 0, 0);
    run_pattern(16'hA5C3, 16'hA5C2, 16'hFFFF, 1'b0, 1'b0, 0, 0);
    run_pattern(16'hA5C3, 16'hA5C2, 16'hFFFE, 1'b0, 1'b0, 0, 0);
    run_pattern(16'h00FF, 16'h00FF, 16'hFFFF, 1'b1, 1'b0, 0, 0);
    // Abort in unload cycle 5 = cycle N+C+1+5; last FAIL (1) must survive.
    run_pattern(16'hA5C3, 16'h0000, 16'hFFFF, 1'b0, 1'b0, N + C + 6, 0);

    // START held high: three back-to-back patterns.
    for (int i = 0; i < 3; i++) begin
      p = N'($urandom);
      run_pattern(p, N'($urandom), N'($urandom), 1'b0, 1'b1, 0, 0);
    end
    start = 1'b0;
    @(negedge ck);

    // ABORT and START together in IDLE: start dropped.
    start = 1'b1; abort = 1'b1; pat_in = 16'h1234;
    @(posedge ck);
    @(negedge ck);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", N'(busy), '0);
    check("idle_abort_se", N'(se), '0);
    @(negedge ck);
    check("idle_abort_busy2", N'(busy), '0);

    // RST during shift cycle 7, then a full clean pattern.
    run_pattern(16'h5A5A, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 0, 7);
    run_pattern(16'h3C96, 16'h3C96, 16'hFFFF, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      p  = N'($urandom);
      iv = 1'($urandom_range(0, 1));
      m  = N'($urandom);
      e  = ($urandom_range(0, 1) == 1) ? (iv ? ~p : p) : N'($urandom);
      run_pattern(p, e, m, iv, 1'b0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
